// File: rtl/fb_writer_pkg.sv
// fb_writer_pkg
// Shared types and constants for the frame-buffer pixel writer:
//   state_t      - swap-control FSM states
//   pixel_req_t  - one buffered write {byte address, RGB565 colour}
//   pix_offset() - byte offset of pixel (x, y) within one buffer
package fb_writer_pkg;

    localparam int BYTES_PER_PIXEL = 2;
    localparam int R_W             = 5;
    localparam int G_W             = 6;
    localparam int B_W             = 5;
    localparam int COLOR_W         = R_W + G_W + B_W;
    localparam int PIX_ADDR_W      = 32;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        WAIT_VS,
        FLIP
    } state_t;

    typedef struct packed {
        logic [PIX_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]    color;
    } pixel_req_t;

    // Row-major byte offset, evaluated entirely at full address width so the
    // y*H_RES product never truncates before the base is added.
    function automatic logic [PIX_ADDR_W-1:0] pix_offset(
        input logic [9:0] x,
        input logic [8:0] y,
        input int         h_res
    );
        logic [PIX_ADDR_W-1:0] idx;
        idx = PIX_ADDR_W'(y) * PIX_ADDR_W'(h_res) + PIX_ADDR_W'(x);
        return idx << $clog2(BYTES_PER_PIXEL);
    endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if
// Bundles the rasteriser pixel stream and the Avalon-MM write bus.
//   master modport - the pixel writer (pixel sink, Avalon master)
//   slave  modport - the environment (pixel source, Avalon slave)
interface fb_pixel_writer_if #(
    parameter int ADDR_W = 32
);
    logic              pix_valid;
    logic              pix_ready;
    logic [9:0]        pix_x;
    logic [8:0]        pix_y;
    logic [15:0]       pix_color;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [15:0]       avm_writedata;
    logic [1:0]        avm_byteenable;
    logic              avm_waitrequest;

    modport master (
        input  pix_valid, pix_x, pix_y, pix_color, avm_waitrequest,
        output pix_ready, avm_address, avm_write, avm_writedata, avm_byteenable
    );

    modport slave (
        output pix_valid, pix_x, pix_y, pix_color, avm_waitrequest,
        input  pix_ready, avm_address, avm_write, avm_writedata, avm_byteenable
    );
endinterface

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo
// Show-ahead FIFO of pixel_req_t: rd_data always presents the head entry.
//   clk, rst        - clock, asynchronous active-high reset
//   push, wr_data   - enqueue (ignored when full)
//   pop, rd_data    - dequeue (ignored when empty) / head entry
//   full, empty     - flags derived from the registered occupancy
// DEPTH must be a power of two, at least 2.
module fb_wr_fifo
    import fb_writer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pixel_req_t wr_data,
    input  logic       pop,
    output pixel_req_t rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    pixel_req_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          wr_en, rd_en;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign wr_en   = push && !full;
    assign rd_en   = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
// Converts a rasteriser (x, y, RGB565) stream into Avalon-MM writes into the
// back buffer and flips front/back buffers during vertical blank.
//   clk, reset       - single clock, asynchronous active-high reset
//   bus (master)     - pixel stream in, Avalon-MM write master out
//   swap_req         - request to present the back buffer
//   vsync            - start-of-vertical-blank pulse
//   swap_done        - pulses in the cycle the buffers are exchanged
//   frame_buffer_ptr - front buffer base for the VGA reader
//   busy             - writes pending or a swap in progress
// Optional (FB_STATS_EN defined):
//   pix_dropped      - saturating count of out-of-range pixels
//   stall_cycles     - saturating count of stalled write cycles
module fb_pixel_writer
    import fb_writer_pkg::*;
#(
    parameter int                H_RES      = 640,
    parameter int                V_RES      = 480,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] FB0_BASE   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] FB1_BASE   = 32'h0010_0000,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    fb_pixel_writer_if.master  bus,
    input  logic               swap_req,
    input  logic               vsync,
    output logic               swap_done,
    output logic [ADDR_W-1:0]  frame_buffer_ptr,
    output logic               busy
`ifdef FB_STATS_EN
    ,
    output logic [15:0]        pix_dropped,
    output logic [15:0]        stall_cycles
`endif
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] front_ptr, back_ptr;
    pixel_req_t        wr_req, head;
    logic              full, empty;
    logic              in_range, accept, push, pop;

    // ---------------- pixel intake ----------------
    assign in_range = (32'(bus.pix_x) < 32'(H_RES)) && (32'(bus.pix_y) < 32'(V_RES));
    assign bus.pix_ready = !full && (state == RUN);
    assign accept   = bus.pix_valid && bus.pix_ready;
    // Out-of-range pixels still handshake so the rasteriser never stalls on them.
    assign push     = accept && in_range;

    // back_ptr is the pre-flip value here, so a pixel accepted alongside
    // swap_req lands in the buffer that is about to be presented.
    assign wr_req.addr  = PIX_ADDR_W'(back_ptr + ADDR_W'(pix_offset(bus.pix_x, bus.pix_y, H_RES)));
    assign wr_req.color = bus.pix_color;

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push    (push),
        .wr_data (wr_req),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // ---------------- Avalon write side ----------------
    // Head of a show-ahead FIFO only moves on pop, so address/data hold
    // naturally under waitrequest. Outputs read zero while idle.
    assign bus.avm_write      = !empty;
    assign bus.avm_address    = empty ? '0 : ADDR_W'(head.addr);
    assign bus.avm_writedata  = empty ? '0 : head.color;
    assign bus.avm_byteenable = 2'b11;
    assign pop = bus.avm_write && !bus.avm_waitrequest;

    // ---------------- swap FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (swap_req) state_nxt = DRAIN;
            DRAIN:   if (empty)    state_nxt = WAIT_VS;
            WAIT_VS: if (vsync)    state_nxt = FLIP;
            FLIP:                  state_nxt = RUN;
            default:               state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_ptr <= FB0_BASE;
            back_ptr  <= FB1_BASE;
        end else if (state == FLIP) begin
            front_ptr <= back_ptr;
            back_ptr  <= front_ptr;
        end
    end

    assign swap_done        = (state == FLIP);
    assign frame_buffer_ptr = front_ptr;
    assign busy             = !empty || (state != RUN);

`ifdef FB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_dropped  <= '0;
            stall_cycles <= '0;
        end else if (state == FLIP) begin
            pix_dropped  <= '0;
            stall_cycles <= '0;
        end else begin
            if (accept && !in_range && pix_dropped != '1)
                pix_dropped <= pix_dropped + 1'b1;
            if (bus.avm_write && bus.avm_waitrequest && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer
// Scoreboard bench: accepted in-range pixels push their expected Avalon write
// into a queue; a negedge monitor pops and compares on every completed write
// and checks address/data stability while stalled.
module tb_fb_pixel_writer;

    localparam logic [31:0] FB0 = 32'h0000_0000;
    localparam logic [31:0] FB1 = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        swap_req = 1'b0;
    logic        vsync = 1'b0;
    logic        swap_done;
    logic        busy;
    logic [31:0] frame_buffer_ptr;
`ifdef FB_STATS_EN
    logic [15:0] pix_dropped;
    logic [15:0] stall_cycles;
`endif

    fb_pixel_writer_if #(.ADDR_W(32)) bus ();

    fb_pixel_writer dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .swap_req         (swap_req),
        .vsync            (vsync),
        .swap_done        (swap_done),
        .frame_buffer_ptr (frame_buffer_ptr),
        .busy             (busy)
`ifdef FB_STATS_EN
        ,
        .pix_dropped      (pix_dropped),
        .stall_cycles     (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int swap_cnt = 0;

    typedef struct {
        logic [31:0] a;
        logic [15:0] d;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic [31:0] prev_a;
    logic [15:0] prev_d;

    always @(negedge clk) begin
        if (swap_done) swap_cnt++;
        if (reset) begin
            prev_stall = 1'b0;
        end else if (bus.avm_write) begin
            if (prev_stall) begin
                chk("stall_addr_stable", bus.avm_address, prev_a);
                chk("stall_data_stable", 32'(bus.avm_writedata), 32'(prev_d));
            end
            if (!bus.avm_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, none owed",
                             bus.avm_address, bus.avm_writedata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.avm_address, e.a);
                    chk("wr_data", 32'(bus.avm_writedata), 32'(e.d));
                    chk("wr_byteenable", 32'(bus.avm_byteenable), 32'd3);
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_a     = bus.avm_address;
                prev_d     = bus.avm_writedata;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] x, input logic [8:0] y,
                        input logic [15:0] c, input logic [31:0] back);
        bit ok;
        int n;
        exp_t ex;
        n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_x     = x;
        bus.pix_y     = y;
        bus.pix_color = c;
        do begin
            ok = bus.pix_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        bus.pix_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pixel (%0d,%0d) never accepted", x, y);
        end else if (x < 10'd640 && y < 9'd480) begin
            ex.a = back + ((32'(y) * 32'd640 + 32'(x)) << 1);
            ex.d = c;
            exp_q.push_back(ex);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.avm_write) && n < 500) begin
            cyc(1);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d writes outstanding", exp_q.size());
        end
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        cyc(1);
        vsync = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.pix_valid       = 1'b0;
        bus.pix_x           = '0;
        bus.pix_y           = '0;
        bus.pix_color       = '0;
        bus.avm_waitrequest = 1'b0;

        // reset state
        cyc(2);
        chk("rst_fb_ptr", frame_buffer_ptr, FB0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        chk("rst_avm_write", 32'(bus.avm_write), 32'd0);
        chk("rst_avm_address", bus.avm_address, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_swap_done", 32'(swap_done), 32'd0);
        reset = 1'b0;
        cyc(1);

        // single pixel, one-cycle latency, one-cycle write
        send(10'd3, 9'd2, 16'hF800, FB1);
        chk("lat_avm_write", 32'(bus.avm_write), 32'd1);
        chk("lat_avm_address", bus.avm_address, 32'h0010_0A06);
        chk("lat_writedata", 32'(bus.avm_writedata), 32'h0000_F800);
        cyc(1);
        chk("single_write_len", 32'(bus.avm_write), 32'd0);

        // back-pressure: 8 fill the FIFO, 2 more wait for the release
        bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 8; i++)
            send(10'(i * 7), 9'(i + 1), 16'(16'h1000 + i), FB1);
        chk("full_pix_ready", 32'(bus.pix_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        cyc(3);
        fork
            begin
                cyc(4);
                bus.avm_waitrequest = 1'b0;
            end
            begin
                send(10'd639, 9'd479, 16'hBEEF, FB1);
                send(10'd100, 9'd200, 16'h07E0, FB1);
            end
        join
        wait_idle();

        // swap with pending writes; vsync during DRAIN is ignored
        bus.avm_waitrequest = 1'b1;
        send(10'd10, 9'd10, 16'h0AAA, FB1);
        send(10'd11, 9'd10, 16'h0BBB, FB1);
        swap_req = 1'b1;
        send(10'd12, 9'd10, 16'h0CCC, FB1);
        swap_req = 1'b0;
        chk("drain_pix_ready", 32'(bus.pix_ready), 32'd0);
        pulse_vsync();
        cyc(2);
        bus.avm_waitrequest = 1'b0;
        wait_idle();
        cyc(3);
        chk("vs_in_drain_swaps", 32'(swap_cnt), 32'd0);
        chk("vs_in_drain_ptr", frame_buffer_ptr, FB0);
        chk("wait_vs_pix_ready", 32'(bus.pix_ready), 32'd0);
        chk("wait_vs_busy", 32'(busy), 32'd1);
        pulse_vsync();
        cyc(2);
        chk("flip_swaps", 32'(swap_cnt), 32'd1);
        chk("flip_ptr", frame_buffer_ptr, FB1);
        chk("flip_pix_ready", 32'(bus.pix_ready), 32'd1);
        chk("flip_busy", 32'(busy), 32'd0);
        send(10'd0, 9'd0, 16'h1234, FB0);
        chk("new_back_address", bus.avm_address, 32'h0000_0000);
        chk("new_back_write", 32'(bus.avm_write), 32'd1);
        wait_idle();

        // out-of-range pixels handshake but never write
        send(10'd640, 9'd0, 16'h001F, FB0);
        send(10'd0, 9'd480, 16'h001F, FB0);
        chk("oor_avm_write", 32'(bus.avm_write), 32'd0);
        cyc(3);
        chk("oor_busy", 32'(busy), 32'd0);
`ifdef FB_STATS_EN
        chk("pix_dropped", 32'(pix_dropped), 32'd2);
        chk("stall_cleared_by_flip", 32'(stall_cycles), 32'd0);
`endif

        // asynchronous reset mid-swap with a write pending
        bus.avm_waitrequest = 1'b1;
        send(10'd1, 9'd1, 16'h5555, FB0);
        swap_req = 1'b1;
        cyc(1);
        swap_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_avm_write", 32'(bus.avm_write), 32'd0);
        chk("midrst_fb_ptr", frame_buffer_ptr, FB0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pix_ready", 32'(bus.pix_ready), 32'd1);
`ifdef FB_STATS_EN
        chk("midrst_pix_dropped", 32'(pix_dropped), 32'd0);
`endif
        exp_q.delete();
        cyc(1);
        reset = 1'b0;
        bus.avm_waitrequest = 1'b0;
        cyc(1);
        send(10'd5, 9'd1, 16'h00FF, FB1);
        chk("post_rst_address", bus.avm_address, 32'h0010_050A);
        wait_idle();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
